display_hdmi_data_pack: RTL
===========================

Name: display_hdmi_data_pack

Overview:
Pixel-to-word packer for the HDMI display path. Takes one PIXEL_BIT pixel per clock with DE/HS/VS timing and groups PACK_DIV consecutive active pixels into one PACK_BIT word. Each word carries a word-index x and line index y, so it can be written into a line buffer or frame writer. This is the write-side counterpart of the display line-buffer unpacker, and it uses the same word layout: first pixel of a group in bits [PIXEL_BIT-1:0].

Parameters:
PIXEL_BIT, 32, bits per pixel
PACK_BIT, 64, bits per packed word; PACK_DIV = PACK_BIT/PIXEL_BIT, legal range 1..8
FIFO_WIDTH, 10, width of x/y counters (word address and line index)

Ports:
in_pclk  input  1  pixel clock, all logic on rising edge
i_arst  input  1  asynchronous reset, active-high
in_de  input  1  active-pixel qualifier
in_hs  input  1  horizontal sync, passed through
in_vs  input  1  vertical sync, active-high; clears line counter
in_data  input  PIXEL_BIT  pixel, sampled when in_de=1
out_x  output  FIFO_WIDTH  word index within line
out_y  output  FIFO_WIDTH  line index
out_valid  output  1  one-cycle strobe: out_data/out_x/out_y valid
out_de  output  1  in_de delayed 1 cycle
out_hs  output  1  in_hs delayed 1 cycle
out_vs  output  1  in_vs delayed 1 cycle
out_data  output  PACK_BIT  packed word
out_x_total  output  FIFO_WIDTH  word count of the last completed line minus 1

Behaviour:
- Clock and reset: one clock, in_pclk. Reset is asynchronous and active-high on i_arst. All outputs and internal state are 0 in reset. A reset mid-line drops any partial group.
- Pixel counter pcnt, 4-bit:
  - Increments on each in_de=1 cycle.
  - Wraps to 0 after PACK_DIV-1.
  - Forced to 0 whenever in_de=0.
- Shift register:
  - A pixel sampled with pcnt=p is written to bits [PIXEL_BIT*(p+1)-1 : PIXEL_BIT*p].
  - On the first pixel of a group (p=0), the remaining slots are cleared to 0.
- Word completion: when a pixel is sampled with pcnt=PACK_DIV-1, in the next cycle:
  - out_valid=1 for exactly one cycle;
  - out_data holds the full word;
  - out_x holds the current word index.
  - Latency is 1 cycle from the last pixel's sampling edge.
- Word index: after each emitted word, the word index increments. It resets to 0 on the in_de falling edge, after any flush. It wraps modulo 2^FIFO_WIDTH without error.
- Line end (in_de 1->0, detected with in_de_1P):
  - out_x_total <= index of the last word emitted in that line, including a flushed word.
  - The line counter increments by 1 in the same cycle.
- out_y: holds the line index of the current word. It is not changed by the line-end increment until the next line's first word.
- in_vs=1 (level): the line counter is cleared to 0. If this coincides with a line end, the clear wins; the flush still occurs and carries the pre-clear y.
- PACK_DIV=1: every active pixel produces out_valid and no partial groups exist.
- DE/HS/VS path: single register stage, so out_de/out_hs/out_vs stay aligned with out_valid of the completing pixel.
- Throughput: back-to-back lines are supported with in_de low for a minimum of 1 cycle. A word and a flush never collide, because a flush happens only in the cycle after the in_de falling edge, when no new group can have completed.

Optional Feature:
Macro: PACK_PARTIAL_FLUSH_EN
- Defined: if in_de falls with pcnt!=0 (line length not a multiple of PACK_DIV), the partial word is emitted in the cycle after the falling edge. Unused high slots are zero, and out_x is the next word index.
- Undefined: the partial group is discarded, no out_valid is raised, and out_x_total counts complete words only.

Test Plan:
- Reset with i_arst pulsed mid-line (pcnt=1) -> all outputs 0 immediately (asynchronous); the next line starts at out_x=0 with no stale word.
- Defaults, line of 8 pixels 0x1..0x8 -> 4 strobes, out_data 0x00000002_00000001 .. 0x00000008_00000007, out_x 0..3, each 1 cycle after the even-numbered pixel; out_x_total=3.
- Line of 5 pixels, flush defined -> 3rd word 0x00000000_00000005 at out_x=2 in the cycle after in_de falls, out_x_total=2. Flush undefined -> 2 words, out_x_total=1.
- 3 lines, in_vs high before line 0 -> out_y 0,1,2. in_vs asserted coincident with line-2 in_de fall -> next frame's words carry out_y=0.
- FIFO_WIDTH=3, line of 20 pixels -> out_x sequence 0..7,0,1 (wrap), no stall.
- PACK_DIV=1 (PACK_BIT=32) -> out_valid equals in_de delayed 1 cycle, out_data equals in_data delayed 1 cycle.

Source files
------------

// File: rtl/display_hdmi_data_pack.sv
// rtl/display_hdmi_data_pack.sv - packs PACK_BIT/PIXEL_BIT active pixels per word with x/y word addressing
// Optional PACK_PARTIAL_FLUSH_EN: emit a zero-padded partial word when a line ends mid-group.
module display_hdmi_data_pack #(
  parameter int PIXEL_BIT  = 32,
  parameter int PACK_BIT   = 64,
  parameter int FIFO_WIDTH = 10
) (
  input  logic                  in_pclk,
  input  logic                  i_arst,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  input  logic [PIXEL_BIT-1:0]  in_data,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic                  out_valid,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [PACK_BIT-1:0]   out_data,
  output logic [FIFO_WIDTH-1:0] out_x_total
);

  localparam int PACK_DIV = PACK_BIT / PIXEL_BIT;
  localparam logic [3:0] LAST_P = 4'(PACK_DIV - 1);
  localparam logic [FIFO_WIDTH-1:0] ONE = FIFO_WIDTH'(1);

`ifdef PACK_PARTIAL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic [3:0]            pcnt;
  logic [PACK_BIT-1:0]   shreg;
  logic [PACK_BIT-1:0]   word_next;
  logic [FIFO_WIDTH-1:0] x_cnt;
  logic [FIFO_WIDTH-1:0] y_cnt;
  logic                  line_end;

  // out_de doubles as the one-cycle-delayed DE used for falling-edge detection
  assign line_end = out_de && !in_de;

  // first pixel of a group starts from a clean word so unused slots read as zero
  always_comb begin
    word_next = (pcnt == 4'd0) ? '0 : shreg;
    word_next[int'(pcnt) * PIXEL_BIT +: PIXEL_BIT] = in_data;
  end

  always_ff @(posedge in_pclk or posedge i_arst) begin
    if (i_arst) begin
      pcnt        <= '0;
      shreg       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_valid   <= 1'b0;
      out_de      <= 1'b0;
      out_hs      <= 1'b0;
      out_vs      <= 1'b0;
      out_data    <= '0;
      out_x_total <= '0;
    end else begin
      out_de    <= in_de;
      out_hs    <= in_hs;
      out_vs    <= in_vs;
      out_valid <= 1'b0;
      if (in_de) begin
        shreg <= word_next;
        if (pcnt == LAST_P) begin
          pcnt      <= '0;
          out_valid <= 1'b1;
          out_data  <= word_next;
          out_x     <= x_cnt;
          out_y     <= y_cnt;
          x_cnt     <= x_cnt + ONE;
        end else begin
          pcnt <= pcnt + 4'd1;
        end
      end else begin
        pcnt <= '0;
        if (line_end) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + ONE;
          // pcnt still holds the pre-fall count here, so nonzero means a partial group
          if (FLUSH_EN && pcnt != 4'd0) begin
            out_valid   <= 1'b1;
            out_data    <= shreg;
            out_x       <= x_cnt;
            out_y       <= y_cnt;
            out_x_total <= x_cnt;
          end else begin
            out_x_total <= x_cnt - ONE;
          end
        end
      end
      if (in_vs) begin
        y_cnt <= '0;
      end
    end
  end

endmodule
